// File: rtl/sipo_deser_if.sv
// sipo_deser_if -- serial input, parallel output and status bundle for sipo_deser.
// slave modport: the deserializer side (takes serial bits, drives the operand pair).
// master modport: the side that feeds the bit stream and consumes the operand pair.
//
// Handshake: a frame transfers on every rising edge where valid_o && ready_i.
// While valid_o is high and ready_i is low, a_o/b_o hold their values and
// valid_o stays high. valid_o does not wait for ready_i before rising.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             sd_i;
  logic             sv_i;
  logic             sync_i;
  logic             ready_i;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             valid_o;
  logic             busy_o;
  logic             ovr_o;
  logic             perr_o;

  modport slave (
    input  sd_i,
    input  sv_i,
    input  sync_i,
    input  ready_i,
    output a_o,
    output b_o,
    output valid_o,
    output busy_o,
    output ovr_o,
    output perr_o
  );

  modport master (
    output sd_i,
    output sv_i,
    output sync_i,
    output ready_i,
    input  a_o,
    input  b_o,
    input  valid_o,
    input  busy_o,
    input  ovr_o,
    input  perr_o
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in, parallel-out deserializer.
// Shifts an MSB-first bit stream into a frame of two WIDTH-bit operands
// and presents the completed pair on a_o/b_o under a valid/ready handshake.
// A completed frame that finds the output slot full is dropped and sets the
// sticky overrun flag.
//
// Optional feature: define SIPO_PARITY_EN to append one even-parity bit to
// each frame. Frames whose 2*WIDTH+1 bits do not XOR to zero are dropped and
// perr_o pulses for one cycle. Without the macro perr_o is tied low.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sipo_deser_if.slave  bus
);

  localparam int DW = 2 * WIDTH;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif
  localparam int CNT_W = $clog2(FRAME);

  typedef logic [CNT_W-1:0] cnt_t;
  // Counter value at which the next sampled bit completes the frame.
  localparam cnt_t LAST = cnt_t'(FRAME - 1);

  // Front end: bit counter and shift register holding {a,b} in flight.
  cnt_t          cnt_q, cnt_d;
  logic [DW-1:0] sh_q, sh_d;

  // Output slot.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Completion strobe and the word it delivers.
  logic          frame_done;
  logic          frame_ok;
  logic [DW-1:0] word;

  // sync_i wipes the partial frame before the current bit is considered,
  // so a bit sampled alongside sync_i becomes bit 0 of a fresh frame.
  cnt_t          cnt_base;
  logic [DW-1:0] sh_base;

`ifdef SIPO_PARITY_EN
  // Running XOR of the data bits of the frame in flight.
  logic par_q, par_d;
  logic par_base;
  logic perr_q, perr_d;
`endif

  // Frame assembly: counter advance/wrap, left shift, completion detect.
  always_comb begin
    cnt_base   = bus.sync_i ? '0 : cnt_q;
    sh_base    = bus.sync_i ? '0 : sh_q;
    cnt_d      = cnt_base;
    sh_d       = sh_base;
    frame_done = 1'b0;
`ifdef SIPO_PARITY_EN
    par_base   = bus.sync_i ? 1'b0 : par_q;
    par_d      = par_base;
    // The final bit is the parity bit; the data is already in the shifter.
    word       = sh_base;
    frame_ok   = ~(par_base ^ bus.sd_i);
`else
    // The final bit is the last data bit and lands directly in b[0].
    word       = {sh_base[DW-2:0], bus.sd_i};
    frame_ok   = 1'b1;
`endif
    if (bus.sv_i) begin
      if (cnt_base == LAST) begin
        cnt_d      = '0;
        sh_d       = '0;
        frame_done = 1'b1;
`ifdef SIPO_PARITY_EN
        par_d      = 1'b0;
`endif
      end else begin
        cnt_d = cnt_base + cnt_t'(1);
        sh_d  = {sh_base[DW-2:0], bus.sd_i};
`ifdef SIPO_PARITY_EN
        par_d = par_base ^ bus.sd_i;
`endif
      end
    end
  end

  // Output slot: load on completion when empty or draining, else flag overrun.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (frame_done && frame_ok && (!valid_q || bus.ready_i)) begin
      a_d     = word[DW-1:WIDTH];
      b_d     = word[WIDTH-1:0];
      valid_d = 1'b1;
    end else if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end
    if (frame_done && frame_ok && valid_q && !bus.ready_i) begin
      ovr_d = 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  // A bad frame is reported before, and instead of, any overrun decision.
  always_comb begin
    perr_d = frame_done && !frame_ok;
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.a_o     = a_q;
  assign bus.b_o     = b_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (cnt_q != '0);
  assign bus.ovr_o   = ovr_q;
`ifdef SIPO_PARITY_EN
  assign bus.perr_o  = perr_q;
`else
  assign bus.perr_o  = 1'b0;
`endif

  // A held frame stays valid and unchanged until the downstream takes it.
  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_q && !bus.ready_i) |=> (valid_q && $stable(a_q) && $stable(b_q)));

  // Overrun is sticky until reset.
  a_ovr_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
    ovr_q |=> ovr_q);

endmodule
